// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types, default geometry and range check for the
//               data-RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      DMA  = 1'b1
   } arb_state_t;

   localparam logic [31:0] DRAM_BASE_DEF  = 32'h1001_0000;
   localparam int unsigned DRAM_WORDS_DEF = 2048;

   // Word-granular check; the byte offset bits never affect the outcome.
   function automatic logic in_dram(
      input logic [31:0] addr,
      input logic [31:0] base  = DRAM_BASE_DEF,
      input logic [31:0] words = DRAM_WORDS_DEF
   );
      logic [32:0] w_a;
      logic [32:0] w_lo;
      logic [32:0] w_hi;
      w_a  = {1'b0, addr} & ~33'h3;
      w_lo = {1'b0, base};
      w_hi = w_lo + ({1'b0, words} << 2);
      return (w_a >= w_lo) && (w_a < w_hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_burst_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dmem_burst_ctr
// Description : Latches a DMA burst request and generates per-beat addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_burst_ctr
   import dmem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_advance,
   input  logic [31:0] i_addr,
   input  logic        i_we,
   input  logic [3:0]  i_len,
   output logic        o_last,
   output logic        o_we,
   output logic [31:0] o_beat_addr
);

   logic [31:0] r_addr;
   logic [3:0]  r_len;
   logic        r_we;
   logic [3:0]  r_beat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr <= 32'd0;
         r_len  <= 4'd0;
         r_we   <= 1'b0;
         r_beat <= 4'd0;
      end else if (i_load) begin
         r_addr <= i_addr;
         r_len  <= i_len;
         r_we   <= i_we;
         r_beat <= 4'd0;
      end else if (i_advance) begin
         r_beat <= r_beat + 4'd1;
      end
   end

   // Address arithmetic wraps modulo 2^32 by construction.
   assign o_beat_addr = r_addr + {26'd0, r_beat, 2'b00};
   assign o_last      = (r_beat == r_len);
   assign o_we        = r_we;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data RAM between the CPU load/store
//               path (zero latency, default priority) and a burst DMA port.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter logic [31:0] DRAM_BASE    = DRAM_BASE_DEF,
   parameter int unsigned DRAM_WORDS   = DRAM_WORDS_DEF,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [3:0]  dma_len,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        dma_done,
   output logic        mem_ena,
   output logic        mem_wena,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        err
);

   localparam int c_STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

   arb_state_t            r_state;
   logic [c_STARVE_W-1:0] r_starve;
   logic                  r_done;
   logic                  r_err;

   logic        w_in_dma;
   logic        w_cpu_go;
   logic        w_grant;
   logic        w_last;
   logic        w_burst_we;
   logic [31:0] w_beat_addr;
   logic        w_cpu_ok;
   logic        w_beat_ok;
   logic        w_bad;

   assign w_in_dma = (r_state == DMA);
   assign w_cpu_go = (r_state == IDLE) && cpu_req && (r_starve < c_STARVE_MAX);
   assign w_grant  = (r_state == IDLE) && dma_req && (!cpu_req || (r_starve == c_STARVE_MAX));

   dmem_burst_ctr u_burst_ctr (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_grant),
      .i_advance   (w_in_dma && !w_last),
      .i_addr      (dma_addr),
      .i_we        (dma_we),
      .i_len       (dma_len),
      .o_last      (w_last),
      .o_we        (w_burst_we),
      .o_beat_addr (w_beat_addr)
   );

   assign w_cpu_ok  = in_dram(cpu_addr, DRAM_BASE, DRAM_WORDS);
   assign w_beat_ok = in_dram(w_beat_addr, DRAM_BASE, DRAM_WORDS);
   assign w_bad     = (w_cpu_go && !w_cpu_ok) || (w_in_dma && !w_beat_ok);

   always_comb begin
      mem_ena   = 1'b0;
      mem_wena  = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      if (w_in_dma) begin
         mem_ena   = 1'b1;
         mem_wena  = w_burst_we && w_beat_ok;
         mem_addr  = w_beat_addr;
         mem_wdata = dma_wdata;
      end else if (w_cpu_go) begin
         mem_ena   = 1'b1;
         mem_wena  = cpu_we && w_cpu_ok;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   assign cpu_rdata  = (w_cpu_go && w_cpu_ok) ? mem_rdata : 32'd0;
   assign cpu_stall  = cpu_req && !w_cpu_go;
   assign dma_gnt    = w_in_dma;
   assign dma_rvalid = w_in_dma && !w_burst_we;
   assign dma_rdata  = (dma_rvalid && w_beat_ok) ? mem_rdata : 32'd0;
   assign dma_done   = r_done;
   assign err        = r_err;

   // Starvation count saturates; a grant always restarts it from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_starve <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_bad) begin
            r_err <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_state  <= DMA;
                  r_starve <= '0;
               end else if (w_cpu_go && dma_req) begin
                  r_starve <= r_starve + c_STARVE_W'(1);
               end
            end
            DMA: begin
               if (w_last) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
